// File: rtl/cu_cmd_queue.sv
// cu_cmd_queue: validates the one-hot register strobes coming out of the cu
// decoder, queues accepted commands in a small FIFO and hands them to the
// datapath over valid/ready. A halt request freezes intake after the halting
// command until software pulses resume.
module cu_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [10:0]              cu_po,
  input  logic                     cu_valid,
  output logic                     cu_ready,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [1:0]               cmd_sel,
  output logic                     cmd_sel_vld,
  output logic [6:0]               cmd_flags,
  output logic                     halted,
  input  logic                     resume,
  output logic                     err_multi,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = 10;

  localparam logic [LVL_W-1:0] LVL_ZERO = '0;
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;

  logic [ENTRY_W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wrPtr;
  logic [PTR_W-1:0]       r_rdPtr;
  logic [LVL_W-1:0]       r_level;
  logic                   r_errMulti;
  logic [CNT_W-1:0]       r_dropCnt;

  logic [2:0]             w_strobeCnt;
  logic [1:0]             w_selEnc;
  logic [ENTRY_W-1:0]     w_entry;
  logic [ENTRY_W-1:0]     w_head;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_drop;

  // Number of register strobes raised; anything above one is an illegal command.
  assign w_strobeCnt = {2'b00, cu_po[2]} + {2'b00, cu_po[3]} +
                       {2'b00, cu_po[4]} + {2'b00, cu_po[5]};

  // Index of the raised strobe; only meaningful when exactly one is set.
  always_comb begin
    w_selEnc = 2'd0;
    if (cu_po[5]) begin
      w_selEnc = 2'd3;
    end else if (cu_po[4]) begin
      w_selEnc = 2'd2;
    end else if (cu_po[3]) begin
      w_selEnc = 2'd1;
    end
  end

  // A command with no strobe is still legal, it just carries sel=0/sel_vld=0.
  assign w_entry = {(w_strobeCnt == 3'd1),
                    (w_strobeCnt == 3'd1) ? w_selEnc : 2'd0,
                    cu_po[10], cu_po[9], cu_po[8], cu_po[7], cu_po[6],
                    cu_po[1], cu_po[0]};

  assign w_full    = (r_level == LVL_FULL);
  assign cmd_valid = (r_level != LVL_ZERO);
  assign w_pop     = cmd_valid & cmd_ready;

  // A full queue can still take a command in the cycle its head leaves.
  assign cu_ready  = (r_state == RUN) & (~w_full | w_pop);
  assign w_accept  = cu_valid & cu_ready;
  assign w_push    = w_accept & (w_strobeCnt <= 3'd1);
  assign w_drop    = w_accept & (w_strobeCnt > 3'd1);

  assign w_head      = r_mem[r_rdPtr];
  assign cmd_sel_vld = w_head[9];
  assign cmd_sel     = w_head[8:7];
  assign cmd_flags   = w_head[6:0];

  assign halted    = (r_state == HALTED);
  assign err_multi = r_errMulti;
  assign drop_cnt  = r_dropCnt;
  assign level     = r_level;

  // Queue storage; cleared on reset so no stale command shows on the outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wrPtr] <= w_entry;
    end
  end

  // Read/write pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky multi-strobe flag and saturating drop counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_errMulti <= 1'b0;
      r_dropCnt  <= '0;
    end else if (w_drop) begin
      r_errMulti <= 1'b1;
      if (r_dropCnt != {CNT_W{1'b1}}) begin
        r_dropCnt <= r_dropCnt + 1'b1;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Halt sequencing: a queued halting command drains the FIFO, then waits for resume.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RUN: begin
        if (w_push && cu_po[9]) begin
          w_stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if ((r_level == LVL_ZERO) || ((r_level == LVL_ONE) && w_pop)) begin
          w_stateNext = HALTED;
        end
      end
      HALTED: begin
        if (resume) begin
          w_stateNext = RUN;
        end
      end
      default: begin
        w_stateNext = RUN;
      end
    endcase
  end

endmodule
